// File: rtl/top_level.sv
// Self-contained 16x16 unsigned shift-and-add multiplier with local data memory and register file.
// Latency: 24 clock edges from start low to halt; start restarts at PC 0 and suppresses all writes.
module top_level (
    input  logic CLK,
    input  logic rst_n,
    input  logic start,
    output logic halt
);

    logic [7:0] PC;
    logic [7:0] pc_d;
    logic       halt_q;
    logic       halt_d;

    logic       step_en;
    logic       load_en;
    logic       mul_en;
    logic       store_en;
    logic [7:0] ld_addr;
    logic [3:0] ld_idx;
    logic [7:0] st_idx;
    logic [3:0] mul_i;
    logic [7:0] ld_dat;

    assign step_en  = !start && (PC < 8'd24);
    assign load_en  = step_en && (PC < 8'd4);
    assign mul_en   = step_en && (PC >= 8'd4) && (PC < 8'd20);
    assign store_en = step_en && (PC >= 8'd20);
    assign ld_addr  = PC + 8'd1;
    assign ld_idx   = PC[3:0] + 4'd1;
    assign st_idx   = PC - 8'd15;
    // PC 4..19 maps to bit 0..15; the low nibble minus 4 wraps to exactly that.
    assign mul_i    = PC[3:0] - 4'd4;

    if (1) begin : data_mem1
        logic [7:0] core [0:255];

        always_ff @(posedge CLK) begin
            if (store_en) begin
                core[st_idx] <= reg_file1.registers[st_idx[3:0]];
            end
        end
    end

    assign ld_dat = data_mem1.core[ld_addr];

    if (1) begin : reg_file1
        logic [7:0]  registers [0:15];
        logic [15:0] mcand;
        logic [15:0] mplier;
        logic [31:0] acc;
        logic [31:0] sum;

        assign mcand  = {registers[1], registers[2]};
        assign mplier = {registers[3], registers[4]};
        assign acc    = {registers[5], registers[6], registers[7], registers[8]};
        assign sum    = acc + ({16'd0, mcand} << mul_i);

        always_ff @(posedge CLK) begin
            if (load_en) begin
                registers[ld_idx] <= ld_dat;
                if (PC == 8'd0) begin
                    registers[5] <= 8'd0;
                    registers[6] <= 8'd0;
                    registers[7] <= 8'd0;
                    registers[8] <= 8'd0;
                end
            end else if (mul_en && mplier[mul_i]) begin
                registers[5] <= sum[31:24];
                registers[6] <= sum[23:16];
                registers[7] <= sum[15:8];
                registers[8] <= sum[7:0];
            end
        end
    end

    always_comb begin
        pc_d   = PC;
        halt_d = halt_q;
        if (start) begin
            pc_d   = 8'd0;
            halt_d = 1'b0;
        end else if (PC < 8'd24) begin
            pc_d = PC + 8'd1;
            if (PC == 8'd23) begin
                halt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            PC     <= 8'd0;
            halt_q <= 1'b0;
        end else begin
            PC     <= pc_d;
            halt_q <= halt_d;
        end
    end

    assign halt = halt_q;

endmodule

// File: tb/tb_top_level.sv
// Bench for top_level: directed and random multiplies checked against A*B, plus restart and async reset.
module tb_top_level;

    logic CLK;
    logic rst_n;
    logic start;
    logic halt;

    int n_checks;
    int n_fail;

    top_level dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .start (start),
        .halt  (halt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic clear_mem();
        for (int k = 0; k < 256; k++) dut.data_mem1.core[k] = 8'h00;
        for (int k = 0; k < 16; k++) dut.reg_file1.registers[k] = 8'h00;
    endtask

    task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
        dut.data_mem1.core[1] = a[15:8];
        dut.data_mem1.core[2] = a[7:0];
        dut.data_mem1.core[3] = b[15:8];
        dut.data_mem1.core[4] = b[7:0];
    endtask

    function automatic logic [31:0] product_mem();
        return {dut.data_mem1.core[5], dut.data_mem1.core[6],
                dut.data_mem1.core[7], dut.data_mem1.core[8]};
    endfunction

    task automatic hold_start();
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_to_halt(output int edges);
        @(negedge CLK);
        start = 1'b0;
        edges = 0;
        while (halt !== 1'b1 && edges < 200) begin
            @(posedge CLK);
            #1;
            edges++;
        end
    endtask

    task automatic run_to_pc(input int target, output int edges);
        @(negedge CLK);
        start = 1'b0;
        edges = 0;
        while (dut.PC !== 8'(target) && edges < 200) begin
            @(posedge CLK);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        #12;
        n_checks++;
        if (dut.PC !== 8'd0 || halt !== 1'b0) begin
            $display("FAIL reset_state: PC=%0d halt=%b, required PC=0 halt=0", dut.PC, halt);
            n_fail++;
        end
        @(negedge CLK);
        rst_n = 1'b1;
        @(posedge CLK);
        #1;
        n_checks++;
        if (dut.PC !== 8'd0 || halt !== 1'b0) begin
            $display("FAIL start_hold: PC=%0d halt=%b, required PC=0 halt=0", dut.PC, halt);
            n_fail++;
        end
    endtask

    task automatic test_directed();
        int edges;
        clear_mem();
        load_ops(16'h03FF, 16'hFFFB);
        hold_start();
        run_to_halt(edges);
        n_checks++;
        if (edges != 24) begin
            $display("FAIL directed_latency: edges=%0d, required 24", edges);
            n_fail++;
        end
        n_checks++;
        if (product_mem() !== 32'h03FEEC05) begin
            $display("FAIL directed_product: got %h, required 03feec05", product_mem());
            n_fail++;
        end
        n_checks++;
        if (dut.PC !== 8'd24) begin
            $display("FAIL directed_pc: PC=%0d, required 24", dut.PC);
            n_fail++;
        end
        n_checks++;
        if (dut.reg_file1.registers[0] !== 8'h00) begin
            $display("FAIL directed_r0: got %h, required 00", dut.reg_file1.registers[0]);
            n_fail++;
        end
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (dut.PC !== 8'd24 || halt !== 1'b1) begin
            $display("FAIL halt_hold: PC=%0d halt=%b, required PC=24 halt=1", dut.PC, halt);
            n_fail++;
        end
    endtask

    task automatic test_corners();
        logic [15:0] av [3];
        logic [15:0] bv [3];
        logic [31:0] pv [3];
        int edges;
        av[0] = 16'h0000; bv[0] = 16'h1234; pv[0] = 32'h00000000;
        av[1] = 16'hFFFF; bv[1] = 16'hFFFF; pv[1] = 32'hFFFE0001;
        av[2] = 16'h0001; bv[2] = 16'h0001; pv[2] = 32'h00000001;
        for (int t = 0; t < 3; t++) begin
            hold_start();
            load_ops(av[t], bv[t]);
            for (int k = 5; k < 9; k++) dut.data_mem1.core[k] = 8'hA5;
            run_to_halt(edges);
            n_checks++;
            if (edges != 24 || product_mem() !== pv[t]) begin
                $display("FAIL corner_%0d: edges=%0d product=%h, required edges=24 product=%h",
                         t, edges, product_mem(), pv[t]);
                n_fail++;
            end
        end
    endtask

    task automatic test_untouched();
        logic [7:0] snap [256];
        int edges;
        int bad;
        hold_start();
        for (int k = 0; k < 256; k++) dut.data_mem1.core[k] = 8'($urandom);
        load_ops(16'h0001, 16'h0001);
        for (int k = 0; k < 256; k++) snap[k] = dut.data_mem1.core[k];
        run_to_halt(edges);
        n_checks++;
        if (product_mem() !== 32'h00000001) begin
            $display("FAIL unity_product: got %h, required 00000001", product_mem());
            n_fail++;
        end
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if ((k == 0 || k > 8) && dut.data_mem1.core[k] !== snap[k]) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            $display("FAIL untouched_mem: %0d bytes changed, required 0", bad);
            n_fail++;
        end
    endtask

    task automatic test_restart();
        int edges;
        hold_start();
        load_ops(16'h1357, 16'h2468);
        run_to_pc(10, edges);
        n_checks++;
        if (edges != 10) begin
            $display("FAIL restart_reach: edges=%0d, required 10", edges);
            n_fail++;
        end
        @(negedge CLK);
        start = 1'b1;
        dut.data_mem1.core[3] = 8'h0B;
        dut.data_mem1.core[4] = 8'hCD;
        @(posedge CLK);
        #1;
        n_checks++;
        if (dut.PC !== 8'd0 || halt !== 1'b0) begin
            $display("FAIL restart_pc: PC=%0d halt=%b, required PC=0 halt=0", dut.PC, halt);
            n_fail++;
        end
        run_to_halt(edges);
        n_checks++;
        if (edges != 24 || product_mem() !== 32'h1357 * 32'h0BCD) begin
            $display("FAIL restart_product: edges=%0d product=%h, required edges=24 product=%h",
                     edges, product_mem(), 32'h1357 * 32'h0BCD);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        int edges;
        hold_start();
        load_ops(16'hBEEF, 16'h00C3);
        run_to_pc(15, edges);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut.PC !== 8'd0 || halt !== 1'b0) begin
            $display("FAIL async_reset: PC=%0d halt=%b, required PC=0 halt=0", dut.PC, halt);
            n_fail++;
        end
        #1;
        rst_n = 1'b1;
        edges = 0;
        while (halt !== 1'b1 && edges < 200) begin
            @(posedge CLK);
            #1;
            edges++;
        end
        n_checks++;
        if (edges != 24 || product_mem() !== 32'hBEEF * 32'h00C3) begin
            $display("FAIL async_rerun: edges=%0d product=%h, required edges=24 product=%h",
                     edges, product_mem(), 32'hBEEF * 32'h00C3);
            n_fail++;
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] expected;
        int edges;
        for (int t = 0; t < 8; t++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            expected = 32'(a) * 32'(b);
            hold_start();
            load_ops(a, b);
            run_to_halt(edges);
            n_checks++;
            if (edges != 24 || product_mem() !== expected) begin
                $display("FAIL random_%0d: %h*%h edges=%0d product=%h, required edges=24 product=%h",
                         t, a, b, edges, product_mem(), expected);
                n_fail++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        start    = 1'b1;
        rst_n    = 1'b1;
        test_reset();
        test_directed();
        test_corners();
        test_untouched();
        test_restart();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
